// File: rtl/store_buffer_if.sv
// store_buffer_if -- bus bundle between the core's data-memory port, the
// store buffer and the data memory.
//
//   slave  : the store buffer itself (takes core requests, drives memory writes)
//   master : the environment around it (core + data memory)
//
// Core side   : cpu_memwrite, cpu_memread, cpu_addr, cpu_wdata -> buffer
//               cpu_rdata, cpu_stall                           <- buffer
// Memory side : mem_raddr, mem_wreq, mem_waddr, mem_wdata      <- buffer
//               mem_rdata, mem_wack                            -> buffer
interface store_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_memwrite;
    logic          cpu_memread;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;
    logic          mem_wreq;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wack;

    modport slave (
        input  cpu_memwrite, cpu_memread, cpu_addr, cpu_wdata, mem_rdata, mem_wack,
        output cpu_rdata, cpu_stall, mem_raddr, mem_wreq, mem_waddr, mem_wdata
    );

    modport master (
        output cpu_memwrite, cpu_memread, cpu_addr, cpu_wdata, mem_rdata, mem_wack,
        input  cpu_rdata, cpu_stall, mem_raddr, mem_wreq, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/store_buffer.sv
// store_buffer -- posted-write buffer between a single-cycle MIPS core's
// data-memory port and a data memory with a req/ack write port.
//
// Stores retire into a DEPTH-entry circular FIFO in one cycle and drain to
// memory in program order. Loads read memory combinationally.
//
// Ports:
//   clk    : clock, all state on the rising edge
//   reset  : synchronous, active-high
//   bus    : store_buffer_if.slave (core request/response + memory port)
//
// Configuration macro STORE_BUF_FWD_EN:
//   defined     -> loads hitting a buffered store get the youngest buffered data
//   not defined -> loads hitting a buffered store stall until that store drains,
//                  cpu_rdata is always mem_rdata
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic           clk,
    input  logic           reset,
    store_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = AW - 2;

    typedef enum logic {IDLE, REQ} state_t;

    state_t         state_reg, state_next;
    logic [PW-1:0]  head_reg, head_next, tail_reg;
    logic [CW-1:0]  count_reg, remaining;
    logic [TW-1:0]  tag_mem  [DEPTH];
    logic [DW-1:0]  data_mem [DEPTH];
    logic           mem_wreq_reg;
    logic [AW-1:0]  mem_waddr_reg, mem_waddr_next;
    logic [DW-1:0]  mem_wdata_reg, mem_wdata_next;
    logic           push, pop, full_stall, cpu_stall;
    logic [TW-1:0]  cpu_tag;
    logic [DEPTH-1:0] valid_vec, match_vec;

    assign cpu_tag    = bus.cpu_addr[AW-1:2];
    assign full_stall = bus.cpu_memwrite && (count_reg == CW'(DEPTH));
    assign push       = bus.cpu_memwrite && !cpu_stall;
    assign pop        = (state_reg == REQ) && bus.mem_wack;
    assign head_next  = pop ? head_reg + PW'(1) : head_reg;
    // Entries left after this cycle's pop, not counting a same-edge push.
    assign remaining  = count_reg - CW'(pop);

    // An entry is live when its distance from head is below count; the
    // distance also gives its age (larger offset = younger store).
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PW-1:0] offset;
            assign offset        = PW'(gi) - head_reg;
            assign valid_vec[gi] = ({1'b0, offset} < count_reg);
            assign match_vec[gi] = valid_vec[gi] && (tag_mem[gi] == cpu_tag);
        end
    endgenerate

`ifdef STORE_BUF_FWD_EN
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic [PW-1:0] fwd_idx;

    // Walk oldest to youngest so the last hit (youngest) wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_reg + PW'(k);
            if (match_vec[fwd_idx]) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem[fwd_idx];
            end
        end
    end

    assign cpu_stall     = full_stall;
    assign bus.cpu_rdata = fwd_hit ? fwd_data : bus.mem_rdata;
`else
    // Without forwarding, a load that hits a pending store waits until the
    // store has reached memory.
    assign cpu_stall     = full_stall || (bus.cpu_memread && (|match_vec));
    assign bus.cpu_rdata = bus.mem_rdata;
`endif

    assign bus.cpu_stall = cpu_stall;
    assign bus.mem_raddr = bus.cpu_addr;
    assign bus.mem_wreq  = mem_wreq_reg;
    assign bus.mem_waddr = mem_waddr_reg;
    assign bus.mem_wdata = mem_wdata_reg;

    // FIFO storage: plain register arrays, every entry is compared each cycle.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[tail_reg]  <= cpu_tag;
            data_mem[tail_reg] <= bus.cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            if (push) begin
                tail_reg <= tail_reg + PW'(1);
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    // Drain FSM. The output registers are reloaded whenever the current
    // request is done (IDLE, or ack in REQ). If the FIFO would otherwise be
    // empty, the store being pushed on this same edge is forwarded straight
    // into the output registers so there is no extra cycle of latency.
    always_comb begin
        state_next     = state_reg;
        mem_waddr_next = mem_waddr_reg;
        mem_wdata_next = mem_wdata_reg;
        if ((state_reg == IDLE) || pop) begin
            if (remaining != '0) begin
                state_next     = REQ;
                mem_waddr_next = {tag_mem[head_next], 2'b00};
                mem_wdata_next = data_mem[head_next];
            end else if (push) begin
                state_next     = REQ;
                mem_waddr_next = {cpu_tag, 2'b00};
                mem_wdata_next = bus.cpu_wdata;
            end else begin
                state_next     = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            mem_wreq_reg  <= 1'b0;
            mem_waddr_reg <= '0;
            mem_wdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            mem_wreq_reg  <= (state_next == REQ);
            mem_waddr_reg <= mem_waddr_next;
            mem_wdata_reg <= mem_wdata_next;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer -- directed self-checking bench for store_buffer.
// Expectations follow the compiled configuration (STORE_BUF_FWD_EN or not).
module tb_store_buffer;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    store_buffer_if #(.AW(32), .DW(32)) bus ();

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
        bus.cpu_memwrite = 1'b1;
        bus.cpu_addr     = addr;
        bus.cpu_wdata    = data;
        tick();
        bus.cpu_memwrite = 1'b0;
        $display("store addr=0x%08h data=0x%08h", addr, data);
    endtask

    // Check the presented write, ack it for exactly one edge.
    task automatic expect_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
        check({tag, "_wreq"}, 32'(bus.mem_wreq), 32'd1);
        check({tag, "_waddr"}, bus.mem_waddr, addr);
        check({tag, "_wdata"}, bus.mem_wdata, data);
        bus.mem_wack = 1'b1;
        tick();
        bus.mem_wack = 1'b0;
        $display("drain addr=0x%08h data=0x%08h", addr, data);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        bus.cpu_memwrite = 1'b0;
        bus.cpu_memread  = 1'b0;
        bus.cpu_addr     = '0;
        bus.cpu_wdata    = '0;
        bus.mem_rdata    = '0;
        bus.mem_wack     = 1'b0;

        // Reset
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_wreq", 32'(bus.mem_wreq), 32'd0);
        check("rst_stall", 32'(bus.cpu_stall), 32'd0);
        check("rst_waddr", bus.mem_waddr, 32'd0);
        bus.cpu_memread = 1'b1;
        bus.cpu_addr    = 32'h50;
        bus.mem_rdata   = 32'h12345678;
        #1;
        check("rst_load", bus.cpu_rdata, 32'h12345678);
        check("rst_raddr", bus.mem_raddr, 32'h50);
        bus.cpu_memread = 1'b0;
        tick();

        // Store-to-load
        bus.cpu_memwrite = 1'b1;
        bus.cpu_addr     = 32'h50;
        #1;
        check("stl_store_stall", 32'(bus.cpu_stall), 32'd0);
        do_store(32'h50, 32'd7);
        check("stl_wreq_next", 32'(bus.mem_wreq), 32'd1);
        check("stl_waddr", bus.mem_waddr, 32'h50);
        check("stl_wdata", bus.mem_wdata, 32'd7);
        bus.cpu_memread = 1'b1;
        bus.cpu_addr    = 32'h50;
        bus.mem_rdata   = 32'hDEADBEEF;
        #1;
`ifdef STORE_BUF_FWD_EN
        check("stl_fwd_rdata", bus.cpu_rdata, 32'd7);
        check("stl_fwd_stall", 32'(bus.cpu_stall), 32'd0);
        bus.mem_wack = 1'b1;
        tick();
        bus.mem_wack = 1'b0;
`else
        check("stl_nofwd_stall0", 32'(bus.cpu_stall), 32'd1);
        tick();
        check("stl_nofwd_stall1", 32'(bus.cpu_stall), 32'd1);
        bus.mem_wack = 1'b1;
        #1;
        check("stl_nofwd_stall_ack", 32'(bus.cpu_stall), 32'd1);
        tick();
        bus.mem_wack = 1'b0;
        check("stl_nofwd_stall_after", 32'(bus.cpu_stall), 32'd0);
`endif
        check("stl_rdata_mem", bus.cpu_rdata, 32'hDEADBEEF);
        check("stl_drained", 32'(bus.mem_wreq), 32'd0);
        bus.cpu_memread = 1'b0;

        // Full buffer
        for (int i = 0; i < 4; i++) begin
            do_store(32'h10 + 32'(i * 4), 32'hA0 + 32'(i));
        end
        bus.cpu_memwrite = 1'b1;
        bus.cpu_addr     = 32'h30;
        bus.cpu_wdata    = 32'hA4;
        #1;
        check("full_stall", 32'(bus.cpu_stall), 32'd1);
        check("full_head_addr", bus.mem_waddr, 32'h10);
        bus.mem_wack = 1'b1;
        #1;
        check("full_stall_on_ack", 32'(bus.cpu_stall), 32'd1);
        tick();
        bus.mem_wack = 1'b0;
        $display("drain addr=0x00000010 data=0x000000a0");
        check("full_stall_freed", 32'(bus.cpu_stall), 32'd0);
        check("full_next_addr", bus.mem_waddr, 32'h14);
        tick();
        bus.cpu_memwrite = 1'b0;
        $display("store addr=0x00000030 data=0x000000a4");
        expect_write("full_w1", 32'h14, 32'hA1);
        expect_write("full_w2", 32'h18, 32'hA2);
        expect_write("full_w3", 32'h1C, 32'hA3);
        expect_write("full_w4", 32'h30, 32'hA4);
        check("full_empty", 32'(bus.mem_wreq), 32'd0);

        // Ordering and youngest-wins
        do_store(32'h20, 32'd1);
        do_store(32'h20, 32'd2);
        bus.cpu_memread = 1'b1;
        bus.cpu_addr    = 32'h20;
        bus.mem_rdata   = 32'h55;
        #1;
`ifdef STORE_BUF_FWD_EN
        check("ord_youngest", bus.cpu_rdata, 32'd2);
`else
        check("ord_load_stall", 32'(bus.cpu_stall), 32'd1);
`endif
        bus.cpu_memread = 1'b0;
        expect_write("ord_w1", 32'h20, 32'd1);
        expect_write("ord_w2", 32'h20, 32'd2);
        check("ord_empty", 32'(bus.mem_wreq), 32'd0);

        // Slow ack, then back-to-back drain
        do_store(32'h40, 32'h11);
        do_store(32'h44, 32'h22);
        do_store(32'h48, 32'h33);
        for (int i = 0; i < 3; i++) begin
            check("slow_hold_addr", bus.mem_waddr, 32'h40);
            check("slow_hold_data", bus.mem_wdata, 32'h11);
            tick();
        end
        expect_write("slow_w1", 32'h40, 32'h11);
        expect_write("slow_w2", 32'h44, 32'h22);
        expect_write("slow_w3", 32'h48, 32'h33);
        check("slow_empty", 32'(bus.mem_wreq), 32'd0);

        // Reset during REQ
        do_store(32'h60, 32'h61);
        do_store(32'h64, 32'h62);
        check("rreq_pending", 32'(bus.mem_wreq), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rreq_wreq", 32'(bus.mem_wreq), 32'd0);
        check("rreq_waddr", bus.mem_waddr, 32'd0);
        bus.cpu_memread = 1'b1;
        bus.cpu_addr    = 32'h60;
        bus.mem_rdata   = 32'hCAFEF00D;
        #1;
        check("rreq_load", bus.cpu_rdata, 32'hCAFEF00D);
        check("rreq_stall", 32'(bus.cpu_stall), 32'd0);
        bus.cpu_memread = 1'b0;
        tick();
        tick();
        check("rreq_still_idle", 32'(bus.mem_wreq), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the single-cycle MIPS core's data-memory port (`aluout` as address, `writedata`, `readdata`) and a data memory whose write port needs a request/acknowledge handshake. Stores retire from the core in one cycle into a small FIFO and drain to memory in program order. Loads read memory combinationally and, when the address matches a pending store, take the youngest buffered data. The core stalls only when a store arrives while the buffer is full.

## Interface
- `DEPTH`, 4: number of buffered stores; power of two, ≥2.
- `AW`, 32: address width; bits [1:0] ignored, word-granular.
- `DW`, 32: data width.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `cpu_memwrite`  in  1  store this cycle.
- `cpu_memread`  in  1  load this cycle.
- `cpu_addr`  in  AW  byte address (core `aluout`).
- `cpu_wdata`  in  DW  store data (core `writedata`).
- `cpu_rdata`  out  DW  load data (core `readdata`), combinational.
- `cpu_stall`  out  1  core must hold PC and retry this instruction.
- `mem_raddr`  out  AW  memory read address; equals `cpu_addr`, combinational.
- `mem_rdata`  in  DW  asynchronous memory read data.
- `mem_wreq`  out  1  write request, registered.
- `mem_waddr`  out  AW  write address, registered.
- `mem_wdata`  out  DW  write data, registered.
- `mem_wack`  in  1  write accepted this cycle.

## Operation
- Storage: circular FIFO of `DEPTH` entries {addr[AW-1:2], data}, with head/tail pointers and a count of width clog2(DEPTH)+1. Pointers wrap modulo `DEPTH`.
- Push: `cpu_memwrite & ~cpu_stall` at a rising edge writes {cpu_addr, cpu_wdata} at the tail.
- Stall: `cpu_stall = cpu_memwrite & (count == DEPTH)`. The stall stays asserted in a cycle where an ack frees an entry; the store is accepted on the next edge.
- Drain FSM:
  - IDLE: `mem_wreq` = 0. If count > 0 (including an entry pushed this edge), go to REQ and load the head entry into `mem_waddr`/`mem_wdata`.
  - REQ: `mem_wreq` = 1. Address and data stay stable until `mem_wack`.
  - On `mem_wack` in REQ: pop the head. If entries remain (including one pushed the same edge), stay in REQ and present the next head on the next cycle with no bubble. Otherwise go to IDLE.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Load path: `cpu_rdata` = data of the youngest valid entry whose addr[AW-1:2] matches, otherwise `mem_rdata`. An entry being popped this cycle still forwards.
- `cpu_memread` and `cpu_memwrite` asserted together is illegal. The store is accepted and `cpu_rdata` is don't-care.
- `mem_wack` outside REQ is ignored.

## Timing
- Reset values: count 0, pointers 0, FSM IDLE, `mem_wreq` 0, `mem_waddr` 0, `mem_wdata` 0, `cpu_stall` 0.
- Store accepted at edge N gives `mem_wreq` = 1 from cycle N+1 if the buffer was empty.
- Drain throughput: one write per cycle when `mem_wack` is held high.
- Load forwarding is zero-latency (combinational). There is no load stall when forwarding is compiled in.
- Reset mid-handshake: the pending request and all entries are dropped and `mem_wreq` falls after the reset edge. Memory must tolerate the abandoned request.

## Configuration
- `STORE_BUF_FWD_EN` defined: store-to-load forwarding as described above.
- Not defined:
  - `cpu_rdata` = `mem_rdata` always.
  - `cpu_stall` also asserts when `cpu_memread` and any valid entry matches addr[AW-1:2].
  - The stall holds until no matching entry remains, so the load then reads committed memory.

## Test plan
- Reset: hold `reset` 2 cycles with `mem_wack` = 0 → `mem_wreq` = 0, `cpu_stall` = 0, `mem_waddr` = 0, and a load of 0x50 returns `mem_rdata`.
- Store-to-load (`sw $7,68($3)` then `lw $2,80($0)`):
  - Stimulus: store addr 0x50, data 7, with `mem_wack` = 0; next cycle load 0x50 with `mem_rdata` = 0xDEADBEEF.
  - With the macro: `cpu_rdata` = 7 and `cpu_stall` = 0.
  - Without the macro: `cpu_stall` = 1 until an ack, then `cpu_rdata` = 0xDEADBEEF.
- Full: 4 stores (0x10..0x1C) with `mem_wack` = 0, then a 5th store → `cpu_stall` = 1. Pulse `mem_wack` for one cycle → memory gets 0x10, and the 5th store is accepted on the following edge.
- Ordering and youngest-wins:
  - Stimulus: store 0x20←1, then 0x20←2; load 0x20 before any ack.
  - Required: `cpu_rdata` = 2; memory then sees writes (0x20,1) and (0x20,2) in that order.
- Slow ack:
  - Stimulus: 3 queued stores; the first ack comes after 3 cycles, then `mem_wack` is held high.
  - Required: `mem_waddr`/`mem_wdata` stable during the wait, then three consecutive one-cycle writes with no bubble.
- Reset during REQ: 2 entries pending with `mem_wack` = 0, assert `reset` → `mem_wreq` = 0 next cycle, buffer empty, and a load of a previously buffered address returns `mem_rdata`.
